abp_packet_tx_mc: RTL and testbench

Multi-channel, width-generalised alternating-bit-protocol packet transmitter. It accepts ABP hyperdata (value, bit) from NUM_CHANNELS independent producers and buffers one request per channel. A round-robin arbiter selects the next channel, and the block emits a fixed-size ABP packet on one AXI-Stream output to the MAC, with full tready backpressure. It replaces the single-channel, byte-wide transmitter in the ABP TX path and adds a channel-ID header byte and a selectable echo/increment mode.

---
 rtl/abp_pkg.sv | 31 +++
 rtl/abp_rr_arbiter.sv | 32 +++
 rtl/abp_packet_tx_mc.sv | 154 +++++++++++++++
 tb/tb_abp_packet_tx_mc.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abp_pkg.sv
// Shared types, header offsets and the packet byte map for the ABP
// multi-channel transmitter.
package abp_pkg;

  typedef enum logic {IDLE, SEND} abp_tx_state_t;

  localparam int unsigned ABP_CHAN_OFS  = 0;
  localparam int unsigned ABP_VALUE_OFS = 1;
  localparam int unsigned ABP_MAX_VBITS = 256;

  // Byte idx of a packet; value is right-aligned in the wide vector.
  function automatic logic [7:0] abp_packet_byte(
    input int unsigned              idx,
    input logic [7:0]               chan,
    input logic [ABP_MAX_VBITS-1:0] value,
    input logic                     abit,
    input int unsigned              vsize,
    input int unsigned              psize
  );
    logic [7:0] b;
    b = 8'h00;
    if (idx == ABP_CHAN_OFS)
      b = chan;
    else if (idx >= ABP_VALUE_OFS && idx < ABP_VALUE_OFS + vsize)
      b = 8'(value >> (8 * (vsize - 1 - (idx - ABP_VALUE_OFS))));
    else if (idx == psize - 1)
      b = {7'b0, abit};
    return b;
  endfunction

endpackage

// File: rtl/abp_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant,
// wrapping. The pointer register lives in the parent.
module abp_rr_arbiter #(
  parameter int NUM_CHANNELS = 2,
  parameter int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [CW-1:0]           last_grant,
  output logic [NUM_CHANNELS-1:0] gnt_oh,
  output logic [CW-1:0]           gnt_idx
);

  always_comb begin
    int best;
    int d;
    best    = NUM_CHANNELS;
    d       = 0;
    gnt_idx = '0;
    gnt_oh  = '0;
    // d is the distance past last_grant; smallest requesting d wins
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      d = (i + NUM_CHANNELS - 1 - int'(last_grant)) % NUM_CHANNELS;
      if (req[i] && d < best) begin
        best    = d;
        gnt_idx = CW'(i);
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++)
      gnt_oh[i] = (best < NUM_CHANNELS) && (gnt_idx == CW'(i));
  end

endmodule

// File: rtl/abp_packet_tx_mc.sv
// Multi-channel ABP packet transmitter: per-channel request slots,
// round-robin grant, fixed-size packet out on one AXI-Stream port.
module abp_packet_tx_mc
  import abp_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VALUE_SIZE   = 4,
  parameter int PACKET_SIZE  = 64,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                               aclk,
  input  logic                               reset,
  output logic                               m_eth_tx_tvalid,
  input  logic                               m_eth_tx_tready,
  output logic                               m_eth_tx_tlast,
  output logic [DATA_WIDTH-1:0]              m_eth_tx_tdata,
  input  logic [NUM_CHANNELS-1:0]            s_abp_valid,
  output logic [NUM_CHANNELS-1:0]            s_abp_ready,
  input  logic [NUM_CHANNELS*VALUE_SIZE*8-1:0] s_abp_value,
  input  logic [NUM_CHANNELS-1:0]            s_abp_bit,
  input  logic                               cfg_increment,
  output logic                               busy,
  output logic [31:0]                        tx_packet_count
);

  localparam int B      = DATA_WIDTH / 8;
  localparam int NBEATS = PACKET_SIZE / B;
  localparam int VW     = VALUE_SIZE * 8;
  localparam int CW     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [VW-1:0]           slot_val [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] slot_bit;
  logic [NUM_CHANNELS-1:0] slot_full;
  logic [NUM_CHANNELS-1:0] full_nxt;
  logic [NUM_CHANNELS-1:0] accept;
  logic [NUM_CHANNELS-1:0] gnt_oh;
  logic [CW-1:0]           gnt_idx;
  logic [CW-1:0]           last_grant;

  abp_tx_state_t state;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] ctx_chan;
  logic [VW-1:0] ctx_val;
  logic          ctx_bit;
  logic          grant;
  logic          last_beat;

  function automatic logic [DATA_WIDTH-1:0] beat_data(
    input int unsigned n,
    input logic [CW-1:0] chan,
    input logic [VW-1:0] v,
    input logic b
  );
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int j = 0; j < B; j++)
      d[8*j +: 8] = abp_packet_byte(n * B + j, 8'(chan),
                      ABP_MAX_VBITS'(v), b, VALUE_SIZE, PACKET_SIZE);
    return d;
  endfunction

  abp_rr_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .CW(CW)
  ) u_arb (
    .req(slot_full),
    .last_grant(last_grant),
    .gnt_oh(gnt_oh),
    .gnt_idx(gnt_idx)
  );

  assign accept    = s_abp_valid & s_abp_ready;
  assign grant     = (state == IDLE) && (|slot_full);
  assign last_beat = (32'(beat_cnt) == NBEATS - 1);

  always_comb begin
    full_nxt = slot_full;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (grant && gnt_oh[i]) full_nxt[i] = 1'b0;
      if (accept[i])          full_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      slot_full   <= '0;
      s_abp_ready <= '0;
      slot_bit    <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
        slot_val[i] <= '0;
    end else begin
      slot_full   <= full_nxt;
      s_abp_ready <= ~full_nxt;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (accept[i]) begin
          slot_val[i] <= s_abp_value[i*VW +: VW] + VW'(cfg_increment);
          slot_bit[i] <= s_abp_bit[i];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      last_grant      <= CW'(NUM_CHANNELS - 1);
      ctx_chan        <= '0;
      ctx_val         <= '0;
      ctx_bit         <= 1'b0;
      m_eth_tx_tvalid <= 1'b0;
      m_eth_tx_tlast  <= 1'b0;
      m_eth_tx_tdata  <= '0;
      busy            <= 1'b0;
      tx_packet_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            ctx_chan        <= gnt_idx;
            ctx_val         <= slot_val[gnt_idx];
            ctx_bit         <= slot_bit[gnt_idx];
            last_grant      <= gnt_idx;
            beat_cnt        <= '0;
            m_eth_tx_tdata  <= beat_data(0, gnt_idx,
                                 slot_val[gnt_idx], slot_bit[gnt_idx]);
            m_eth_tx_tvalid <= 1'b1;
            m_eth_tx_tlast  <= (NBEATS == 1);
            busy            <= 1'b1;
            state           <= SEND;
          end
        end
        SEND: begin
          if (m_eth_tx_tready) begin
            if (last_beat) begin
              m_eth_tx_tvalid <= 1'b0;
              m_eth_tx_tlast  <= 1'b0;
              busy            <= 1'b0;
              tx_packet_count <= tx_packet_count + 32'd1;
              state           <= IDLE;
            end else begin
              beat_cnt       <= beat_cnt + 1'b1;
              m_eth_tx_tdata <= beat_data(32'(beat_cnt) + 1,
                                  ctx_chan, ctx_val, ctx_bit);
              m_eth_tx_tlast <= (32'(beat_cnt) + 2 == NBEATS);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abp_packet_tx_mc.sv
// Scoreboard bench for abp_packet_tx_mc: byte-wide 2-channel instance
// plus a 32-bit/16-byte instance for lane mapping.
module tb_abp_packet_tx_mc;

  logic        aclk;
  logic        reset;
  logic        tvalid, tready, tlast;
  logic [7:0]  tdata;
  logic [1:0]  s_valid, s_ready, s_bit;
  logic [63:0] s_value;
  logic        cfg_inc;
  logic        busy;
  logic [31:0] cnt;

  logic        w_tvalid, w_tready, w_tlast;
  logic [31:0] w_tdata;
  logic [1:0]  w_valid, w_ready, w_bit;
  logic [63:0] w_value;
  logic        w_inc, w_busy;
  logic [31:0] w_cnt;

  logic [8:0]  q[$];
  logic [32:0] qw[$];
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int hs_total = 0;
  bit rand_mode = 0;

  bit         in_frame = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_d;
  logic       prev_l;
  bit         gap_mode = 0;
  bit         gap_chk = 0;
  int         gap_cnt = 0;

  abp_packet_tx_mc #(
    .DATA_WIDTH(8), .VALUE_SIZE(4), .PACKET_SIZE(64), .NUM_CHANNELS(2)
  ) dut (
    .aclk(aclk), .reset(reset),
    .m_eth_tx_tvalid(tvalid), .m_eth_tx_tready(tready),
    .m_eth_tx_tlast(tlast), .m_eth_tx_tdata(tdata),
    .s_abp_valid(s_valid), .s_abp_ready(s_ready),
    .s_abp_value(s_value), .s_abp_bit(s_bit),
    .cfg_increment(cfg_inc), .busy(busy), .tx_packet_count(cnt)
  );

  abp_packet_tx_mc #(
    .DATA_WIDTH(32), .VALUE_SIZE(4), .PACKET_SIZE(16), .NUM_CHANNELS(2)
  ) dut32 (
    .aclk(aclk), .reset(reset),
    .m_eth_tx_tvalid(w_tvalid), .m_eth_tx_tready(w_tready),
    .m_eth_tx_tlast(w_tlast), .m_eth_tx_tdata(w_tdata),
    .s_abp_valid(w_valid), .s_abp_ready(w_ready),
    .s_abp_value(w_value), .s_abp_bit(w_bit),
    .cfg_increment(w_inc), .busy(w_busy), .tx_packet_count(w_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input int idx,
      input logic [7:0] ch, input logic [31:0] v, input logic b);
    if (idx == 0) return ch;
    if (idx >= 1 && idx <= 4) return 8'(v >> (8 * (4 - idx)));
    if (idx == 63) return {7'b0, b};
    return 8'h00;
  endfunction

  task automatic push_pkt(input logic ch, input logic [31:0] v,
      input logic b, input logic inc);
    logic [31:0] vp;
    vp = v + 32'(inc);
    for (int i = 0; i < 64; i++)
      q.push_back({(i == 63), exp_byte(i, 8'(ch), vp, b)});
    exp_cnt++;
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      tready = rand_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Scoreboard monitor; handshakes land on the following rising edge
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge aclk);
      if (reset) begin
        in_frame = 0;
        prev_stall = 0;
        gap_mode = 0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!tvalid || tdata !== prev_d || tlast !== prev_l) begin
            errors++;
            $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, want 1 %h %b",
                     tvalid, tdata, tlast, prev_d, prev_l);
          end
        end
        if (in_frame) begin
          checks++;
          if (tvalid !== 1'b1) begin
            errors++;
            $display("FAIL tvalid_drop: tvalid=%b inside frame, want 1", tvalid);
          end
        end
        if (gap_mode && tvalid) begin
          if (gap_chk) begin
            checks++;
            if (gap_cnt != 1) begin
              errors++;
              $display("FAIL idle_gap: got %0d idle cycles, want 1", gap_cnt);
            end
          end
          gap_mode = 0;
        end else if (gap_mode) begin
          gap_cnt++;
        end
        if (tvalid && tready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat: got data=%h last=%b, want no beat",
                     tdata, tlast);
          end else begin
            e = q.pop_front();
            if ({tlast, tdata} !== e) begin
              errors++;
              $display("FAIL beat %0d: got last=%b data=%h, want last=%b data=%h",
                       hs_total, tlast, tdata, e[8], e[7:0]);
            end
          end
          hs_total++;
          if (tlast) begin
            in_frame = 0;
            gap_mode = 1;
            gap_cnt = 0;
            gap_chk = (q.size() > 0);
          end else begin
            in_frame = 1;
          end
        end
        prev_stall = tvalid && !tready;
        prev_d = tdata;
        prev_l = tlast;
      end
    end
  end

  task automatic send_req(input logic ch, input logic [31:0] v,
      input logic b);
    int n;
    if (ch) s_value[63:32] = v;
    else    s_value[31:0]  = v;
    s_bit[ch] = b;
    s_valid[ch] = 1'b1;
    for (n = 0; n < 400 && !s_ready[ch]; n++) cyc();
    if (!s_ready[ch]) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: ch%0d ready=%b, want 1", ch, s_ready[ch]);
    end else begin
      push_pkt(ch, v, b, cfg_inc);
      cyc();
    end
    s_valid[ch] = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && (q.size() != 0 || busy); n++) cyc();
    checks++;
    if (q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain: %0d beats pending busy=%b, want 0 0",
               q.size(), busy);
      q.delete();
    end
    checks++;
    if (cnt !== 32'(exp_cnt)) begin
      errors++;
      $display("FAIL pkt_count: got %0d, want %0d", cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({tvalid, tlast, tdata} !== 10'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b l=%b d=%h, want 0 0 00",
               tvalid, tlast, tdata);
    end
    checks++;
    if (s_ready !== 2'b00 || w_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b, want 00/00", s_ready, w_ready);
    end
    checks++;
    if (busy !== 1'b0 || cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: busy=%b cnt=%0d, want 0 0", busy, cnt);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (s_ready !== 2'b11 || w_ready !== 2'b11) begin
      errors++;
      $display("FAIL ready_release: got %b/%b, want 11/11", s_ready, w_ready);
    end
  endtask

  task automatic test_single();
    cfg_inc = 1'b1;
    s_value[31:0] = 32'h0000_00FF;
    s_bit[0] = 1'b1;
    s_valid[0] = 1'b1;
    push_pkt(1'b0, 32'h0000_00FF, 1'b1, 1'b1);
    cyc();
    s_valid[0] = 1'b0;
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: tvalid=%b one cycle after accept, want 0",
               tvalid);
    end
    cyc();
    checks++;
    if (tvalid !== 1'b1 || busy !== 1'b1 || tdata !== 8'h00) begin
      errors++;
      $display("FAIL first_beat: v=%b busy=%b d=%h, want 1 1 00",
               tvalid, busy, tdata);
    end
    checks++;
    if (s_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL ready_regrant: got %b, want 1", s_ready[0]);
    end
    drain(200);
  endtask

  task automatic test_wide();
    int n;
    w_tready = 1'b1;
    w_value[63:32] = 32'h1234_5678;
    w_bit[1] = 1'b0;
    qw.push_back({1'b0, 32'h5634_1201});
    qw.push_back({1'b0, 32'h0000_0078});
    qw.push_back({1'b0, 32'h0000_0000});
    qw.push_back({1'b1, 32'h0000_0000});
    w_valid[1] = 1'b1;
    cyc();
    w_valid[1] = 1'b0;
    for (n = 0; n < 50 && qw.size() != 0; n++) begin
      if (w_tvalid && w_tready) begin
        logic [32:0] e;
        e = qw.pop_front();
        checks++;
        if ({w_tlast, w_tdata} !== e) begin
          errors++;
          $display("FAIL wide_beat: got last=%b data=%h, want last=%b data=%h",
                   w_tlast, w_tdata, e[32], e[31:0]);
        end
      end
      cyc();
    end
    checks++;
    if (qw.size() != 0 || w_cnt !== 32'd1) begin
      errors++;
      $display("FAIL wide_done: %0d beats pending cnt=%0d, want 0 1",
               qw.size(), w_cnt);
      qw.delete();
    end
  endtask

  task automatic test_wrap();
    cfg_inc = 1'b1;
    send_req(1'b0, 32'hFFFF_FFFF, 1'b0);
    cfg_inc = 1'b0;
    drain(200);
    send_req(1'b1, 32'hFFFF_FFFF, 1'b1);
    drain(200);
  endtask

  task automatic test_back_to_back();
    cfg_inc = 1'b1;
    s_value = {32'h0BAD_0001, 32'h0000_1000};
    s_bit = 2'b01;
    s_valid = 2'b11;
    push_pkt(1'b0, 32'h0000_1000, 1'b1, 1'b1);
    push_pkt(1'b1, 32'h0BAD_0001, 1'b0, 1'b1);
    cyc();
    s_valid = 2'b00;
    checks++;
    if (s_ready !== 2'b00) begin
      errors++;
      $display("FAIL both_full: ready=%b, want 00", s_ready);
    end
    cyc();
    checks++;
    if (s_ready !== 2'b01 || tvalid !== 1'b1 || tdata !== 8'h00) begin
      errors++;
      $display("FAIL first_grant: ready=%b v=%b d=%h, want 01 1 00",
               s_ready, tvalid, tdata);
    end
    send_req(1'b0, 32'hA5A5_0001, 1'b1);
    drain(600);
  endtask

  task automatic test_random_tready();
    rand_mode = 1;
    cfg_inc = 1'b0;
    send_req(1'b1, 32'hDEAD_BEEF, 1'b1);
    send_req(1'b0, 32'h0102_0304, 1'b0);
    send_req(1'b1, 32'h7FFF_FFFF, 1'b0);
    drain(3000);
    rand_mode = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    int n;
    cfg_inc = 1'b0;
    send_req(1'b0, 32'h1122_3344, 1'b0);
    base = hs_total;
    for (n = 0; n < 300 && hs_total - base < 20; n++) cyc();
    checks++;
    if (hs_total - base < 20) begin
      errors++;
      $display("FAIL mid_progress: got %0d beats, want 20", hs_total - base);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || s_ready !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: v=%b l=%b ready=%b, want 0 0 00",
               tvalid, tlast, s_ready);
    end
    checks++;
    if (busy !== 1'b0 || cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_status: busy=%b cnt=%0d, want 0 0", busy, cnt);
    end
    q.delete();
    exp_cnt = 0;
    reset = 1'b0;
    cyc();
    checks++;
    if (s_ready !== 2'b11) begin
      errors++;
      $display("FAIL mid_release: ready=%b, want 11", s_ready);
    end
    send_req(1'b1, 32'hCAFE_F00D, 1'b1);
    drain(200);
  endtask

  initial begin
    reset = 1'b1;
    s_valid = '0;
    s_value = '0;
    s_bit = '0;
    cfg_inc = 1'b0;
    w_valid = '0;
    w_value = '0;
    w_bit = '0;
    w_inc = 1'b0;
    w_tready = 1'b1;
    test_reset();
    test_single();
    test_wide();
    test_wrap();
    test_back_to_back();
    test_random_tready();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
